vend_controller: RTL and testbench

- Transaction engine directly downstream of the keypad front end. It consumes that stage's registered fields: usermode, stuffmode, sizein, addsize, cmoney and withdrawmoney.
- On each confirm-button press it executes one operation: insert money, buy, restock, or refund/withdraw.
- It owns per-item stock counters, customer credit and the machine's cash bank.
- It drives handshaked dispense and payout requests to the actuator stage.

---
 rtl/vend_controller.sv | 265 ++++++++++++++++++++++++++
 tb/tb_vend_controller.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// vend_controller
//   Transaction engine behind the keypad front end. Each rising edge of the
//   confirm button (go) latches one operation (insert money, buy, restock,
//   refund/withdraw). The operation is evaluated in a single EXEC cycle.
//   Its result is either a done/err pulse or a handshaked dispense/payout
//   request. The block owns per-item stock, customer credit and the cash bank.
//
// Ports
//   clock           in   system clock, rising edge
//   reset_n         in   synchronous active-low reset
//   go              in   confirm button level (debounced)
//   usermode[1:0]   in   0=INSERT 1=BUY 2=RESTOCK 3=WITHDRAW
//   stuffmode[2:0]  in   item index
//   sizein[3:0]     in   buy quantity
//   addsize[3:0]    in   restock quantity
//   cmoney[3:0]     in   coin value
//   withdrawmoney   in   bank withdrawal amount, 0 = refund customer credit
//   dispense_ready  in   actuator accepts dispense request
//   pay_ready       in   cash unit accepts payout request
//   credit[7:0]     out  customer credit
//   bank[11:0]      out  cash held by the machine
//   dispense_valid/item/qty   out  dispense request and payload
//   pay_valid/pay_amt         out  payout request and payload
//   done, err       out  one-cycle completion / rejection pulses
//   err_code[2:0]   out  last rejection reason (held)
//   busy            out  engine not idle
module vend_controller #(
  parameter int          ITEMS      = 6,
  parameter logic [31:0] PRICES     = 32'h87654321,
  parameter int          INIT_STOCK = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        go,
  input  logic [1:0]  usermode,
  input  logic [2:0]  stuffmode,
  input  logic [3:0]  sizein,
  input  logic [3:0]  addsize,
  input  logic [3:0]  cmoney,
  input  logic [3:0]  withdrawmoney,
  input  logic        dispense_ready,
  input  logic        pay_ready,
  output logic [7:0]  credit,
  output logic [11:0] bank,
  output logic        dispense_valid,
  output logic [2:0]  dispense_item,
  output logic [3:0]  dispense_qty,
  output logic        pay_valid,
  output logic [7:0]  pay_amt,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        busy
);

  localparam logic [2:0] E_BAD_ITEM   = 3'd1;
  localparam logic [2:0] E_BAD_QTY    = 3'd2;
  localparam logic [2:0] E_NO_STOCK   = 3'd3;
  localparam logic [2:0] E_NO_CREDIT  = 3'd4;
  localparam logic [2:0] E_CREDIT_OVF = 3'd5;
  localparam logic [2:0] E_NO_FUNDS   = 3'd6;

  localparam logic [3:0] ITEMS_L = 4'(ITEMS);
  localparam logic [3:0] STOCK_L = 4'(INIT_STOCK);

  typedef enum logic [1:0] {IDLE, EXEC, DISPENSE, PAYOUT} state_t;

  state_t      state, state_n;
  logic        go_q;
  logic        trigger;
  logic        latch_en;

  logic [1:0]  op_mode;
  logic [2:0]  op_item;
  logic [3:0]  op_size, op_add, op_coin, op_wd;

  logic [3:0]  stock [ITEMS];
  logic        stock_we;
  logic [3:0]  stock_wd;
  logic [3:0]  stock_cur;

  logic        item_ok;
  logic [3:0]  price;
  logic [7:0]  cost;
  logic [8:0]  ins_sum;

  logic [7:0]  credit_n;
  logic [11:0] bank_n;
  logic        dv_n, pv_n, done_n, err_n;
  logic [2:0]  di_n, code_n;
  logic [3:0]  dq_n;
  logic [7:0]  pa_n;

  function automatic logic [11:0] sat_bank_add(input logic [11:0] b, input logic [7:0] c);
    logic [12:0] s;
    s = {1'b0, b} + {5'd0, c};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

  function automatic logic [3:0] sat_stock_add(input logic [3:0] s, input logic [3:0] a);
    logic [4:0] t;
    t = {1'b0, s} + {1'b0, a};
    return t[4] ? 4'hF : t[3:0];
  endfunction

  assign trigger   = go & ~go_q;
  assign busy      = (state != IDLE);
  assign item_ok   = ({1'b0, op_item} < ITEMS_L);
  assign stock_cur = item_ok ? stock[op_item] : 4'd0;
  assign price     = PRICES[{op_item, 2'b00} +: 4];
  // Largest case is 15*15 = 225, so 8 bits never overflow.
  assign cost      = {4'd0, price} * {4'd0, op_size};
  assign ins_sum   = {1'b0, credit} + {5'd0, op_coin};

  always_comb begin
    state_n  = state;
    latch_en = 1'b0;
    credit_n = credit;
    bank_n   = bank;
    stock_we = 1'b0;
    stock_wd = stock_cur;
    dv_n     = dispense_valid;
    di_n     = dispense_item;
    dq_n     = dispense_qty;
    pv_n     = pay_valid;
    pa_n     = pay_amt;
    done_n   = 1'b0;
    err_n    = 1'b0;
    code_n   = err_code;
    case (state)
      IDLE: begin
        if (trigger) begin
          latch_en = 1'b1;
          state_n  = EXEC;
        end
      end
      EXEC: begin
        state_n = IDLE;
        case (op_mode)
          2'd0: begin
            if (ins_sum[8]) begin
              err_n = 1'b1; code_n = E_CREDIT_OVF;
            end else begin
              credit_n = ins_sum[7:0];
              done_n   = 1'b1;
            end
          end
          2'd1: begin
            if (!item_ok) begin
              err_n = 1'b1; code_n = E_BAD_ITEM;
            end else if (op_size == 4'd0) begin
              err_n = 1'b1; code_n = E_BAD_QTY;
            end else if (stock_cur < op_size) begin
              err_n = 1'b1; code_n = E_NO_STOCK;
            end else if (cost > credit) begin
              err_n = 1'b1; code_n = E_NO_CREDIT;
            end else begin
              // Accounting is committed now; the handshake only moves goods.
              stock_we = 1'b1;
              stock_wd = stock_cur - op_size;
              credit_n = credit - cost;
              bank_n   = sat_bank_add(bank, cost);
              dv_n     = 1'b1;
              di_n     = op_item;
              dq_n     = op_size;
              state_n  = DISPENSE;
            end
          end
          2'd2: begin
            if (!item_ok) begin
              err_n = 1'b1; code_n = E_BAD_ITEM;
            end else begin
              stock_we = 1'b1;
              stock_wd = sat_stock_add(stock_cur, op_add);
              done_n   = 1'b1;
            end
          end
          default: begin
            if (op_wd == 4'd0) begin
              // Refund of customer credit; nothing to pay when credit is empty.
              if (credit == 8'd0) begin
                done_n = 1'b1;
              end else begin
                pa_n     = credit;
                credit_n = 8'd0;
                pv_n     = 1'b1;
                state_n  = PAYOUT;
              end
            end else if (bank < {8'd0, op_wd}) begin
              err_n = 1'b1; code_n = E_NO_FUNDS;
            end else begin
              bank_n  = bank - {8'd0, op_wd};
              pa_n    = {4'd0, op_wd};
              pv_n    = 1'b1;
              state_n = PAYOUT;
            end
          end
        endcase
      end
      DISPENSE: begin
        if (dispense_ready) begin
          dv_n    = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      PAYOUT: begin
        if (pay_ready) begin
          pv_n    = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      // Held high so a button pressed through reset is not seen as an edge.
      go_q           <= 1'b1;
      op_mode        <= 2'd0;
      op_item        <= 3'd0;
      op_size        <= 4'd0;
      op_add         <= 4'd0;
      op_coin        <= 4'd0;
      op_wd          <= 4'd0;
      credit         <= 8'd0;
      bank           <= 12'd0;
      for (int i = 0; i < ITEMS; i++) stock[i] <= STOCK_L;
      dispense_valid <= 1'b0;
      dispense_item  <= 3'd0;
      dispense_qty   <= 4'd0;
      pay_valid      <= 1'b0;
      pay_amt        <= 8'd0;
      done           <= 1'b0;
      err            <= 1'b0;
      err_code       <= 3'd0;
    end else begin
      state          <= state_n;
      go_q           <= go;
      if (latch_en) begin
        op_mode <= usermode;
        op_item <= stuffmode;
        op_size <= sizein;
        op_add  <= addsize;
        op_coin <= cmoney;
        op_wd   <= withdrawmoney;
      end
      credit         <= credit_n;
      bank           <= bank_n;
      if (stock_we) stock[op_item] <= stock_wd;
      dispense_valid <= dv_n;
      dispense_item  <= di_n;
      dispense_qty   <= dq_n;
      pay_valid      <= pv_n;
      pay_amt        <= pa_n;
      done           <= done_n;
      err            <= err_n;
      err_code       <= code_n;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios followed by randomized
// operations, checked through a scoreboard fed by a behavioural model.
module tb_vend_controller;

  localparam int          ITEMS      = 6;
  localparam logic [31:0] PRICES     = 32'h87654321;
  localparam int          INIT_STOCK = 5;

  logic        clock, reset_n, go;
  logic [1:0]  usermode;
  logic [2:0]  stuffmode;
  logic [3:0]  sizein, addsize, cmoney, withdrawmoney;
  logic        dispense_ready, pay_ready;
  logic [7:0]  credit;
  logic [11:0] bank;
  logic        dispense_valid;
  logic [2:0]  dispense_item;
  logic [3:0]  dispense_qty;
  logic        pay_valid;
  logic [7:0]  pay_amt;
  logic        done, err;
  logic [2:0]  err_code;
  logic        busy;

  vend_controller #(.ITEMS(ITEMS), .PRICES(PRICES), .INIT_STOCK(INIT_STOCK)) dut (
    .clock(clock), .reset_n(reset_n), .go(go), .usermode(usermode),
    .stuffmode(stuffmode), .sizein(sizein), .addsize(addsize), .cmoney(cmoney),
    .withdrawmoney(withdrawmoney), .dispense_ready(dispense_ready),
    .pay_ready(pay_ready), .credit(credit), .bank(bank),
    .dispense_valid(dispense_valid), .dispense_item(dispense_item),
    .dispense_qty(dispense_qty), .pay_valid(pay_valid), .pay_amt(pay_amt),
    .done(done), .err(err), .err_code(err_code), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int is_err; int code; int disp; int pay;
    int item; int qty; int amt; int credit; int bank;
  } exp_t;

  exp_t sbq[$];
  exp_t last_exp;
  int   m_credit, m_bank, m_code;
  int   m_stock[ITEMS];
  int   ready_mode = 0;   // 0 random, 1 hold low, 2 hold high

  function automatic int price(int k);
    return int'((PRICES >> (4 * k)) & 32'hF);
  endfunction

  function automatic void model_reset();
    m_credit = 0; m_bank = 0; m_code = 0;
    foreach (m_stock[i]) m_stock[i] = INIT_STOCK;
  endfunction

  function automatic exp_t model(int um, int it, int sz, int add, int cm, int wm);
    exp_t e = '{default: 0};
    int   cost;
    case (um)
      0: if (m_credit + cm > 255) begin e.is_err = 1; e.code = 5; end
         else m_credit += cm;
      1: begin
        if (it >= ITEMS)            begin e.is_err = 1; e.code = 1; end
        else if (sz == 0)           begin e.is_err = 1; e.code = 2; end
        else if (m_stock[it] < sz)  begin e.is_err = 1; e.code = 3; end
        else if (price(it) * sz > m_credit) begin e.is_err = 1; e.code = 4; end
        else begin
          cost = price(it) * sz;
          m_stock[it] -= sz;
          m_credit    -= cost;
          m_bank       = (m_bank + cost > 4095) ? 4095 : m_bank + cost;
          e.disp = 1; e.item = it; e.qty = sz;
        end
      end
      2: begin
        if (it >= ITEMS) begin e.is_err = 1; e.code = 1; end
        else m_stock[it] = (m_stock[it] + add > 15) ? 15 : m_stock[it] + add;
      end
      default: begin
        if (wm == 0) begin
          if (m_credit != 0) begin e.pay = 1; e.amt = m_credit; m_credit = 0; end
        end else if (m_bank < wm) begin
          e.is_err = 1; e.code = 6;
        end else begin
          m_bank -= wm; e.pay = 1; e.amt = wm;
        end
      end
    endcase
    if (e.is_err != 0) m_code = e.code;
    e.code = m_code; e.credit = m_credit; e.bank = m_bank;
    return e;
  endfunction

  // ---------------- ready generator ----------------
  initial begin
    dispense_ready = 1'b0;
    pay_ready      = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        1:       begin dispense_ready = 1'b0; pay_ready = 1'b0; end
        2:       begin dispense_ready = 1'b1; pay_ready = 1'b1; end
        default: begin
          dispense_ready = ($urandom_range(0, 2) == 0);
          pay_ready      = ($urandom_range(0, 2) == 0);
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  bit mon_prev_hs = 0;
  always @(negedge clock) begin
    exp_t e;
    bit   prev;
    if (!reset_n) begin
      mon_prev_hs = 0;
    end else begin
      prev = mon_prev_hs;
      if (done && err) flag("done_and_err_together");
      if (prev) begin
        chk("done_after_handshake", int'(done), 1);
        chk("valid_drop_after_handshake", int'(dispense_valid | pay_valid), 0);
      end
      if (dispense_valid && dispense_ready) begin
        if (sbq.size() == 0) flag("unexpected_dispense");
        else begin
          chk("dispense_expected", 1, sbq[0].disp);
          chk("dispense_item", int'(dispense_item), sbq[0].item);
          chk("dispense_qty", int'(dispense_qty), sbq[0].qty);
        end
      end
      if (pay_valid && pay_ready) begin
        if (sbq.size() == 0) flag("unexpected_payout");
        else begin
          chk("payout_expected", 1, sbq[0].pay);
          chk("pay_amt", int'(pay_amt), sbq[0].amt);
        end
      end
      if (done || err) begin
        if (sbq.size() == 0) flag("unexpected_response");
        else begin
          e = sbq.pop_front();
          chk("err", int'(err), e.is_err);
          chk("err_code", int'(err_code), e.code);
          chk("credit", int'(credit), e.credit);
          chk("bank", int'(bank), e.bank);
          if (e.disp != 0 || e.pay != 0) chk("handshake_before_done", int'(prev), 1);
        end
      end
      mon_prev_hs = (dispense_valid && dispense_ready) || (pay_valid && pay_ready);
    end
  end

  // ---------------- driver ----------------
  task automatic issue_start(int um, int it, int sz, int add, int cm, int wm);
    @(negedge clock);
    go = 1'b0;
    @(negedge clock);
    usermode = 2'(um); stuffmode = 3'(it); sizein = 4'(sz);
    addsize = 4'(add); cmoney = 4'(cm); withdrawmoney = 4'(wm);
    go = 1'b1;
    last_exp = model(um, it, sz, add, cm, wm);
    sbq.push_back(last_exp);
  endtask

  task automatic wait_done(input bit scramble, input bit check_lat);
    int n   = 0;
    bit got = 0;
    while (!got && n < 200) begin
      @(negedge clock);
      n++;
      if (done || err) got = 1;
      else if (scramble) begin
        // Inputs and button activity while busy must be ignored.
        go = 1'($urandom); usermode = 2'($urandom); stuffmode = 3'($urandom);
        sizein = 4'($urandom); addsize = 4'($urandom);
        cmoney = 4'($urandom); withdrawmoney = 4'($urandom);
      end
    end
    go = 1'b0;
    if (!got) flag("timeout_waiting_for_done");
    else if (check_lat) begin
      if (last_exp.disp == 0 && last_exp.pay == 0) chk("latency_no_handshake", n, 2);
      else if (ready_mode == 2) chk("latency_handshake", n, 3);
    end
  endtask

  task automatic issue(int um, int it, int sz, int add, int cm, int wm);
    issue_start(um, it, sz, add, cm, wm);
    wait_done(1'b1, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_credit"}, int'(credit), 0);
    chk({tag, "_bank"}, int'(bank), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_err_code"}, int'(err_code), 0);
    chk({tag, "_dispense_valid"}, int'(dispense_valid), 0);
    chk({tag, "_pay_valid"}, int'(pay_valid), 0);
    chk({tag, "_pay_amt"}, int'(pay_amt), 0);
    chk({tag, "_dispense_item"}, int'(dispense_item), 0);
    chk({tag, "_dispense_qty"}, int'(dispense_qty), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int um, wm;
    bit seen;
    reset_n = 1'b0; go = 1'b1;
    usermode = 2'd0; stuffmode = 3'd0; sizein = 4'd0;
    addsize = 4'd0; cmoney = 4'd0; withdrawmoney = 4'd0;
    model_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    // go stays high across reset release: no operation may start
    repeat (4) @(negedge clock);
    check_reset_outputs("reset");
    go = 1'b0;

    // Stock of every item is exactly INIT_STOCK: qty 6 fails on stock,
    // qty 5 passes the stock check and fails on credit.
    for (int k = 0; k < ITEMS; k++) begin
      issue(1, k, INIT_STOCK + 1, 0, 0, 0);
      issue(1, k, INIT_STOCK, 0, 0, 0);
    end

    ready_mode = 2;
    issue(0, 0, 0, 0, 9, 0);
    issue(0, 0, 0, 0, 9, 0);
    chk("credit_after_two_inserts", int'(credit), 18);

    // BUY item 2 qty 4 with the actuator stalled for 5 cycles
    ready_mode = 1;
    issue_start(1, 2, 4, 0, 0, 0);
    @(negedge clock);
    repeat (5) begin
      @(negedge clock);
      go = ~go;
      chk("dispense_hold_valid", int'(dispense_valid), 1);
      chk("dispense_hold_item", int'(dispense_item), 2);
      chk("dispense_hold_qty", int'(dispense_qty), 4);
    end
    ready_mode = 2;
    wait_done(1'b0, 1'b0);
    chk("credit_after_buy", int'(credit), 6);
    chk("bank_after_buy", int'(bank), 12);

    issue(1, 7, 1, 0, 0, 0);
    issue(1, 2, 2, 0, 0, 0);
    issue(1, 5, 2, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0);
    issue(2, 2, 0, 15, 0, 0);
    issue(2, 6, 0, 3, 0, 0);
    issue(1, 2, 15, 0, 0, 0);   // stock saturated at 15, fails on credit
    issue(3, 0, 0, 0, 0, 0);
    issue(3, 0, 0, 0, 0, 13);
    issue(3, 0, 0, 0, 0, 12);
    chk("bank_after_withdraw", int'(bank), 0);

    issue(0, 0, 0, 0, 9, 0);
    issue(0, 0, 0, 0, 9, 0);
    repeat (15) issue(0, 0, 0, 0, 15, 0);
    chk("credit_243", int'(credit), 243);
    issue(0, 0, 0, 0, 15, 0);
    chk("credit_after_ovf", int'(credit), 243);
    chk("err_code_ovf", int'(err_code), 5);

    // Reset while a payout request is pending
    ready_mode = 1;
    issue_start(3, 0, 0, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (pay_valid) seen = 1;
    end
    if (!seen) flag("pay_valid_never_asserted");
    chk("pay_amt_pending", int'(pay_amt), 243);
    reset_n = 1'b0;
    @(negedge clock);
    check_reset_outputs("mid_payout_reset");
    reset_n = 1'b1;
    sbq.delete();
    model_reset();
    go = 1'b0;
    ready_mode = 0;
    repeat (2) @(negedge clock);

    // Randomized operations
    repeat (300) begin
      um = $urandom_range(0, 5);
      if (um > 3) um = 0;         // bias toward inserts to keep credit flowing
      wm = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 15);
      issue(um, $urandom_range(0, 7), $urandom_range(0, 6),
            $urandom_range(0, 15), $urandom_range(0, 15), wm);
    end
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
